// File: rtl/tnet_tx_arb.sv
// Purpose: packet-level arbiter sharing one 64-bit link TX stream between the
//          local command source and the forward (relay) path.
// Latency: 1 arbitration cycle per packet, then 1 registered output stage.
// Backpressure: source tready follows the output register's free slot (~tvalid_o | tready_i).
//
// Ports:
//   c_clk_i, c_rst_i          core clock, async active-high reset
//   loc_t*_i / loc_tready_o   local command stream (tProc control ops)
//   fwd_t*_i / fwd_tready_o   forward stream (packets relayed from the other channel)
//   prio_loc_i                1 = local strict priority, 0 = round-robin
//   clr_i                     single-cycle clear of packet counters and stall flag
//   axi_tx_t*_o / _tready_i   Aurora TX user stream
//   busy_o                    packet in progress or output beat pending
//   stall_err_o               sticky: output stalled for TIMEOUT consecutive cycles
//   loc_cnt_o / fwd_cnt_o     packets sent per source (wrap modulo 2^CNT_W)

module tnet_tx_arb #(
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk_i,
  input  logic             c_rst_i,

  input  logic             loc_tvalid_i,
  input  logic [DW-1:0]    loc_tdata_i,
  input  logic             loc_tlast_i,
  output logic             loc_tready_o,

  input  logic             fwd_tvalid_i,
  input  logic [DW-1:0]    fwd_tdata_i,
  input  logic             fwd_tlast_i,
  output logic             fwd_tready_o,

  input  logic             prio_loc_i,
  input  logic             clr_i,

  output logic [DW-1:0]    axi_tx_tdata_o,
  output logic             axi_tx_tvalid_o,
  output logic             axi_tx_tlast_o,
  input  logic             axi_tx_tready_i,

  output logic             busy_o,
  output logic             stall_err_o,
  output logic [CNT_W-1:0] loc_cnt_o,
  output logic [CNT_W-1:0] fwd_cnt_o
);

  // Stall counter must be able to hold TIMEOUT itself (it saturates there).
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOC  = 2'd1;
  localparam logic [1:0] S_FWD  = 2'd2;

  // Source tag / last-grant encoding.
  localparam logic SRC_LOC = 1'b0;
  localparam logic SRC_FWD = 1'b1;

  localparam logic [SW-1:0]    STALL_MAX = SW'(TIMEOUT);
  localparam logic [SW-1:0]    STALL_PRE = SW'(TIMEOUT - 1);
  localparam logic [SW-1:0]    STALL_ONE = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q,     state_d;
  logic             last_gnt_q,  last_gnt_d;
  logic [DW-1:0]    dat_q,       dat_d;
  logic             vld_q,       vld_d;
  logic             last_q,      last_d;
  logic             tag_q,       tag_d;
  logic [CNT_W-1:0] loc_cnt_q,   loc_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             err_q,       err_d;

  logic out_free;
  logic loc_acc;
  logic fwd_acc;
  logic out_hs;
  logic stalled;
  logic pkt_done;

  // The output register can take a new beat when it is empty or draining now.
  assign out_free = ~vld_q | axi_tx_tready_i;

  assign loc_tready_o = (state_q == S_LOC) & out_free;
  assign fwd_tready_o = (state_q == S_FWD) & out_free;

  assign loc_acc = loc_tvalid_i & loc_tready_o;
  assign fwd_acc = fwd_tvalid_i & fwd_tready_o;

  assign out_hs   = vld_q & axi_tx_tready_i;
  assign stalled  = vld_q & ~axi_tx_tready_i;
  assign pkt_done = out_hs & last_q;

  // ---------------------------------------------------------------------------
  // Arbitration FSM. A grant is only decided in IDLE and then held until the
  // granted source's tlast beat is accepted, so packets never interleave.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      S_IDLE: begin
        // Local wins when alone, under strict priority, or when forward had
        // the previous grant; otherwise forward takes it if it is asking.
        if (loc_tvalid_i && (!fwd_tvalid_i || prio_loc_i || (last_gnt_q == SRC_FWD))) begin
          state_d    = S_LOC;
          last_gnt_d = SRC_LOC;
        end else if (fwd_tvalid_i) begin
          state_d    = S_FWD;
          last_gnt_d = SRC_FWD;
        end
      end
      S_LOC: begin
        if (loc_acc && loc_tlast_i) begin
          state_d = S_IDLE;
        end
      end
      S_FWD: begin
        if (fwd_acc && fwd_tlast_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register. Payload is only rewritten on an accepted beat, so it is
  // automatically stable while the link stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    last_d = last_q;
    tag_d  = tag_q;
    if (loc_acc) begin
      vld_d  = 1'b1;
      dat_d  = loc_tdata_i;
      last_d = loc_tlast_i;
      tag_d  = SRC_LOC;
    end else if (fwd_acc) begin
      vld_d  = 1'b1;
      dat_d  = fwd_tdata_i;
      last_d = fwd_tlast_i;
      tag_d  = SRC_FWD;
    end else if (axi_tx_tready_i) begin
      vld_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet counters. Clear is applied first so a coincident completion still
  // counts (result = 1).
  // ---------------------------------------------------------------------------
  always_comb begin
    loc_cnt_d = clr_i ? '0 : loc_cnt_q;
    fwd_cnt_d = clr_i ? '0 : fwd_cnt_q;
    if (pkt_done) begin
      if (tag_q == SRC_LOC) begin
        loc_cnt_d = loc_cnt_d + CNT_ONE;
      end else begin
        fwd_cnt_d = fwd_cnt_d + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog. Counts consecutive cycles with a pending beat that the link
  // refuses; the flag sets on the cycle the count reaches TIMEOUT. The data is
  // kept, only the condition is reported.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (stalled) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + STALL_ONE;
    end else begin
      stall_cnt_d = '0;
    end
    // Set on the reaching transition takes precedence over a same-cycle clear.
    err_d = (stalled && (stall_cnt_q == STALL_PRE)) | (err_q & ~clr_i);
  end

  always_ff @(posedge c_clk_i or posedge c_rst_i) begin
    if (c_rst_i) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= SRC_FWD;
      vld_q       <= 1'b0;
      dat_q       <= '0;
      last_q      <= 1'b0;
      tag_q       <= SRC_LOC;
      loc_cnt_q   <= '0;
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      loc_cnt_q   <= loc_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign axi_tx_tdata_o  = dat_q;
  assign axi_tx_tvalid_o = vld_q;
  assign axi_tx_tlast_o  = last_q;
  assign busy_o          = (state_q != S_IDLE) | vld_q;
  assign stall_err_o     = err_q;
  assign loc_cnt_o       = loc_cnt_q;
  assign fwd_cnt_o       = fwd_cnt_q;

endmodule

// File: tb/tb_tnet_tx_arb.sv
// Directed bench for tnet_tx_arb: local-only timing, round-robin, strict
// priority, backpressure hold, watchdog/clear, reset mid-packet and counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_tnet_tx_arb;

  localparam int DW = 64;

  logic          c_clk_i = 1'b0;
  logic          c_rst_i;
  logic          loc_tvalid_i, loc_tlast_i, loc_tready_o;
  logic [DW-1:0] loc_tdata_i;
  logic          fwd_tvalid_i, fwd_tlast_i, fwd_tready_o;
  logic [DW-1:0] fwd_tdata_i;
  logic          prio_loc_i, clr_i;
  logic [DW-1:0] axi_tx_tdata_o;
  logic          axi_tx_tvalid_o, axi_tx_tlast_o, axi_tx_tready_i;
  logic          busy_o, stall_err_o;
  logic [3:0]    loc_cnt_o, fwd_cnt_o;

  tnet_tx_arb #(.DW(DW), .TIMEOUT(8), .CNT_W(4)) dut (
    .c_clk_i         (c_clk_i),
    .c_rst_i         (c_rst_i),
    .loc_tvalid_i    (loc_tvalid_i),
    .loc_tdata_i     (loc_tdata_i),
    .loc_tlast_i     (loc_tlast_i),
    .loc_tready_o    (loc_tready_o),
    .fwd_tvalid_i    (fwd_tvalid_i),
    .fwd_tdata_i     (fwd_tdata_i),
    .fwd_tlast_i     (fwd_tlast_i),
    .fwd_tready_o    (fwd_tready_o),
    .prio_loc_i      (prio_loc_i),
    .clr_i           (clr_i),
    .axi_tx_tdata_o  (axi_tx_tdata_o),
    .axi_tx_tvalid_o (axi_tx_tvalid_o),
    .axi_tx_tlast_o  (axi_tx_tlast_o),
    .axi_tx_tready_i (axi_tx_tready_i),
    .busy_o          (busy_o),
    .stall_err_o     (stall_err_o),
    .loc_cnt_o       (loc_cnt_o),
    .fwd_cnt_o       (fwd_cnt_o)
  );

  always #5 c_clk_i = ~c_clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Source models: beat data = 0xA00/0xB00 | pkt<<4 | beat.
  bit auto_drv;
  bit loc_en, fwd_en;
  int loc_len, loc_lim, loc_pkt, loc_beat;
  int fwd_len, fwd_lim, fwd_pkt, fwd_beat;
  int stall_n, fwd_rdy_seen;
  logic [63:0] out_q[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task update_drv();
    if (auto_drv) begin
      loc_tvalid_i = loc_en && (loc_pkt < loc_lim);
      loc_tdata_i  = 64'hA00 | (64'(loc_pkt) << 4) | 64'(loc_beat);
      loc_tlast_i  = (loc_beat == loc_len - 1);
      fwd_tvalid_i = fwd_en && (fwd_pkt < fwd_lim);
      fwd_tdata_i  = 64'hB00 | (64'(fwd_pkt) << 4) | 64'(fwd_beat);
      fwd_tlast_i  = (fwd_beat == fwd_len - 1);
    end
  endtask

  task tick();
    bit lh, fh, st;
    @(negedge c_clk_i);
    lh = loc_tvalid_i & loc_tready_o;
    fh = fwd_tvalid_i & fwd_tready_o;
    st = axi_tx_tvalid_o & ~axi_tx_tready_i;
    if (st) begin
      stall_n++;
      chk("stall_rdy", {62'd0, loc_tready_o, fwd_tready_o}, 64'd0);
      if (exp_q.size() > out_q.size())
        chk("stall_hold", axi_tx_tdata_o, exp_q[out_q.size()]);
    end
    if (fwd_tready_o && (loc_pkt < loc_lim)) fwd_rdy_seen++;
    if (axi_tx_tvalid_o && axi_tx_tready_i) out_q.push_back(axi_tx_tdata_o);
    @(posedge c_clk_i);
    #1;
    if (lh) begin
      if (loc_beat == loc_len - 1) begin loc_beat = 0; loc_pkt++; end
      else loc_beat++;
    end
    if (fh) begin
      if (fwd_beat == fwd_len - 1) begin fwd_beat = 0; fwd_pkt++; end
      else fwd_beat++;
    end
    update_drv();
  endtask

  task do_reset();
    c_rst_i = 1'b1;
    auto_drv = 1; loc_en = 0; fwd_en = 0;
    loc_len = 1; loc_lim = 0; loc_pkt = 0; loc_beat = 0;
    fwd_len = 1; fwd_lim = 0; fwd_pkt = 0; fwd_beat = 0;
    prio_loc_i = 1'b0; clr_i = 1'b0; axi_tx_tready_i = 1'b1;
    stall_n = 0; fwd_rdy_seen = 0;
    out_q.delete(); exp_q.delete();
    update_drv();
    repeat (2) @(posedge c_clk_i);
    #1 c_rst_i = 1'b0;
  endtask

  task check_log(input string tag);
    chk({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk(tag, out_q[i], exp_q[i]);
  endtask

  task wait_idle(input string tag);
    for (int i = 0; i < 300 && ((loc_pkt < loc_lim) || (fwd_en && fwd_pkt < fwd_lim) || busy_o); i++) tick();
    chk({tag, "_done"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    // ---- reset state ----
    c_rst_i = 1'b1;
    loc_tvalid_i = 0; loc_tdata_i = '0; loc_tlast_i = 0;
    fwd_tvalid_i = 0; fwd_tdata_i = '0; fwd_tlast_i = 0;
    prio_loc_i = 0; clr_i = 0; axi_tx_tready_i = 1;
    #1;
    chk("rst_vld",  64'(axi_tx_tvalid_o), 64'd0);
    chk("rst_dat",  axi_tx_tdata_o, 64'd0);
    chk("rst_misc", {56'd0, axi_tx_tlast_o, busy_o, stall_err_o, loc_tready_o, fwd_tready_o, 3'd0}, 64'd0);
    chk("rst_cnt",  {56'd0, loc_cnt_o, fwd_cnt_o}, 64'd0);

    // ---- local only, exact cycle timing ----
    do_reset();
    auto_drv = 0;
    loc_tvalid_i = 1; loc_tdata_i = 64'h11; loc_tlast_i = 0;
    #1 chk("lo_idle_rdy", 64'(loc_tready_o), 64'd0);
    tick();
    chk("lo_gnt_rdy", 64'(loc_tready_o), 64'd1);
    chk("lo_gnt_vld", 64'(axi_tx_tvalid_o), 64'd0);
    tick();
    chk("lo_b1", {axi_tx_tvalid_o, axi_tx_tlast_o, axi_tx_tdata_o[61:0]}, {2'b10, 62'h11});
    loc_tdata_i = 64'h22;
    tick();
    chk("lo_b2", {axi_tx_tvalid_o, axi_tx_tlast_o, axi_tx_tdata_o[61:0]}, {2'b10, 62'h22});
    loc_tdata_i = 64'h33; loc_tlast_i = 1;
    tick();
    chk("lo_b3", {axi_tx_tvalid_o, axi_tx_tlast_o, axi_tx_tdata_o[61:0]}, {2'b11, 62'h33});
    chk("lo_back_idle_rdy", 64'(loc_tready_o), 64'd0);
    loc_tvalid_i = 0; loc_tlast_i = 0;
    tick();
    chk("lo_end", {56'd0, loc_cnt_o, fwd_cnt_o}, 64'h10);
    chk("lo_end_busy", {62'd0, axi_tx_tvalid_o, busy_o}, 64'd0);

    // ---- round-robin, 2-beat packets ----
    do_reset();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(64'hA00 | (64'(p) << 4)); exp_q.push_back(64'hA01 | (64'(p) << 4));
      exp_q.push_back(64'hB00 | (64'(p) << 4)); exp_q.push_back(64'hB01 | (64'(p) << 4));
    end
    loc_en = 1; fwd_en = 1; loc_len = 2; fwd_len = 2; loc_lim = 3; fwd_lim = 3;
    update_drv();
    wait_idle("rr");
    check_log("rr_beat");
    chk("rr_cnt", {56'd0, loc_cnt_o, fwd_cnt_o}, 64'h33);

    // ---- strict priority ----
    do_reset();
    prio_loc_i = 1;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(64'hA00 | (64'(p) << 4)); exp_q.push_back(64'hA01 | (64'(p) << 4));
    end
    exp_q.push_back(64'hB00); exp_q.push_back(64'hB01);
    loc_en = 1; fwd_en = 1; loc_len = 2; fwd_len = 2; loc_lim = 4; fwd_lim = 1;
    update_drv();
    wait_idle("sp");
    check_log("sp_beat");
    chk("sp_fwd_rdy", 64'(fwd_rdy_seen), 64'd0);
    chk("sp_cnt", {56'd0, loc_cnt_o, fwd_cnt_o}, 64'h41);

    // ---- backpressure mid-packet: ready 1,0,0,1 ----
    do_reset();
    for (int b = 0; b < 4; b++) exp_q.push_back(64'hA00 | 64'(b));
    loc_en = 1; loc_len = 4; loc_lim = 1;
    update_drv();
    for (int i = 0; i < 20 && !axi_tx_tvalid_o; i++) tick();
    chk("bp_start", 64'(axi_tx_tvalid_o), 64'd1);
    axi_tx_tready_i = 1; tick();
    axi_tx_tready_i = 0; tick();
    axi_tx_tready_i = 0; tick();
    axi_tx_tready_i = 1; tick();
    wait_idle("bp");
    check_log("bp_beat");
    chk("bp_stalls", 64'(stall_n), 64'd2);

    // ---- watchdog and clear ----
    do_reset();
    exp_q.push_back(64'hA00); exp_q.push_back(64'hA10);
    axi_tx_tready_i = 0;
    loc_en = 1; loc_len = 1; loc_lim = 1;
    update_drv();
    for (int i = 0; i < 20 && !axi_tx_tvalid_o; i++) tick();
    chk("wd_start", 64'(axi_tx_tvalid_o), 64'd1);
    repeat (7) tick();
    chk("wd_err_7", 64'(stall_err_o), 64'd0);
    tick();
    chk("wd_err_8", 64'(stall_err_o), 64'd1);
    repeat (2) tick();
    chk("wd_err_10", 64'(stall_err_o), 64'd1);
    axi_tx_tready_i = 1;
    tick();
    chk("wd_drain", {56'd0, stall_err_o, axi_tx_tvalid_o, 2'd0, loc_cnt_o}, {56'd0, 8'b1000_0001});
    clr_i = 1; tick(); clr_i = 0;
    chk("wd_clr", {56'd0, stall_err_o, 3'd0, loc_cnt_o}, 64'd0);
    axi_tx_tready_i = 0; loc_lim = 2;
    update_drv();
    for (int i = 0; i < 20 && !axi_tx_tvalid_o; i++) tick();
    chk("wd_pkt2", 64'(axi_tx_tvalid_o), 64'd1);
    axi_tx_tready_i = 1; clr_i = 1;
    tick();
    clr_i = 0;
    chk("wd_clr_inc", 64'(loc_cnt_o), 64'd1);
    check_log("wd_beat");

    // ---- reset mid-packet ----
    do_reset();
    loc_en = 1; loc_len = 4; loc_lim = 1;
    update_drv();
    for (int i = 0; i < 20 && out_q.size() < 2; i++) tick();
    chk("mr_two_beats", 64'(out_q.size()), 64'd2);
    #2 c_rst_i = 1'b1;
    #1;
    chk("mr_outs", {59'd0, axi_tx_tvalid_o, axi_tx_tlast_o, busy_o, loc_tready_o, fwd_tready_o}, 64'd0);
    chk("mr_dat", axi_tx_tdata_o, 64'd0);
    loc_pkt = 0; loc_beat = 0; loc_len = 1;
    fwd_en = 1; fwd_len = 1; fwd_lim = 1;
    out_q.delete();
    update_drv();
    @(posedge c_clk_i); #1 c_rst_i = 1'b0;
    exp_q.push_back(64'hA00); exp_q.push_back(64'hB00);
    wait_idle("mr");
    check_log("mr_beat");

    // ---- counter wrap (CNT_W = 4) ----
    do_reset();
    loc_en = 1; loc_len = 1; loc_lim = 17;
    update_drv();
    wait_idle("wr");
    chk("wr_cnt", {56'd0, loc_cnt_o, fwd_cnt_o}, 64'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tnet_tx_arb.md
# tnet_tx_arb

Packet-level arbiter that shares one timing-network link TX AXI-stream port (64-bit, per channel A or B) between two requesters. The requesters are the local command source, driven from tProc control operations, and the forward path, which relays packets received on the opposite channel. The block sits between those sources and the Aurora TX user interface. It adds a registered output stage, a stall watchdog and per-source packet counters for the PS register map.

## Interface
Parameters:
- DW, 64, stream data width.
- TIMEOUT, 1024, consecutive stalled cycles before `stall_err_o` sets (≥2).
- CNT_W, 16, packet counter width.

Ports:
- c_clk_i  in  1  core clock; all logic is synchronous to it.
- c_rst_i  in  1  reset, asynchronous, active-high.
- loc_tvalid_i / loc_tdata_i / loc_tlast_i  in  1/DW/1  local command stream.
- loc_tready_o  out  1  local stream ready.
- fwd_tvalid_i / fwd_tdata_i / fwd_tlast_i  in  1/DW/1  forward stream.
- fwd_tready_o  out  1  forward stream ready.
- prio_loc_i  in  1  1 = local has strict priority; 0 = round-robin.
- clr_i  in  1  single-cycle clear of counters and error.
- axi_tx_tdata_o  out  DW  link TX data.
- axi_tx_tvalid_o  out  1  link TX valid.
- axi_tx_tlast_o  out  1  link TX last.
- axi_tx_tready_i  in  1  link TX ready.
- busy_o  out  1  1 when state ≠ IDLE or `axi_tx_tvalid_o` = 1.
- stall_err_o  out  1  sticky stall flag.
- loc_cnt_o  out  CNT_W  local packets sent.
- fwd_cnt_o  out  CNT_W  forwarded packets sent.

## Operation
- States: IDLE, LOC, FWD.
- Reset: state = IDLE, `last_gnt` = FWD (so local wins the first round-robin tie). All outputs are 0.
- IDLE, no valid input: stay in IDLE.
- IDLE, one requester valid: go to that requester's state.
- IDLE, both valid, `prio_loc_i` = 1: go to LOC.
- IDLE, both valid, `prio_loc_i` = 0: go to the requester that is not `last_gnt`.
- Entering LOC or FWD updates `last_gnt`.
- `prio_loc_i` is sampled only in IDLE. A change mid-packet has no effect until the next decision.
- LOC/FWD: `<src>_tready_o` = `~axi_tx_tvalid_o | axi_tx_tready_i`. The non-granted `tready` is 0. `tready` is always 0 in IDLE.
- An accepted beat loads the output register (data, last) and a source tag.
- An accepted beat with `tlast` = 1 returns the state to IDLE.
- Packets are never interleaved. A granted requester keeps the port until its `tlast` beat is accepted, regardless of gaps in its `tvalid`.
- Output register:
  - `axi_tx_tvalid_o` sets on an accepted beat.
  - It clears on `axi_tx_tready_i` when no new beat is accepted in the same cycle.
  - Data, last and tag are held stable while `axi_tx_tvalid_o` = 1 and `axi_tx_tready_i` = 0.
- Counters:
  - The source's counter increments on an output handshake with `axi_tx_tlast_o` = 1, attributed by the source tag.
  - Counters wrap modulo 2^CNT_W.
- Watchdog:
  - `stall_cnt` increments each cycle with `axi_tx_tvalid_o` = 1 and `axi_tx_tready_i` = 0.
  - It resets to 0 on any output handshake or when `axi_tx_tvalid_o` = 0.
  - It saturates at TIMEOUT.
  - `stall_cnt` reaching TIMEOUT sets `stall_err_o`.
  - Data is never dropped; the stall is only flagged.
- `clr_i`:
  - Zeroes both counters and `stall_err_o`; `stall_cnt` is unaffected.
  - Same-cycle increment or set wins over clear: counter = 1 and `stall_err_o` = 1 after that cycle.
- Reset mid-packet: asynchronously returns to IDLE and drops the output beat (`axi_tx_tvalid_o` = 0). The requester must restart its packet.

## Timing
- Arbitration costs 1 cycle per packet. A request seen in IDLE at edge N gives `tready` = 1 during cycle N+1. The first beat appears on the output in cycle N+2.
- Within a packet, throughput is 1 beat/cycle while `axi_tx_tready_i` = 1.
- Back-to-back packets from the same or another source have one idle cycle between a `tlast` acceptance and the next packet's first acceptance.
- `loc_tready_o` / `fwd_tready_o` are combinational from state, `axi_tx_tvalid_o` and `axi_tx_tready_i`. All other outputs are registered.
- `stall_err_o` rises on the cycle after the TIMEOUT-th consecutive stalled cycle.

## Test plan
- Local only: after reset, a 3-beat local packet (0x11, 0x22, 0x33 with last) with `axi_tx_tready_i` = 1. Output carries the 3 beats in cycles 2–4 after `tvalid`; `loc_cnt_o` = 1, `fwd_cnt_o` = 0.
- Round-robin: `prio_loc_i` = 0, both sources continuously offer 2-beat packets for 6 packets. Grant order is LOC, FWD, LOC, FWD, LOC, FWD with no interleaved beats; final counts are 3/3.
- Strict priority: `prio_loc_i` = 1, both continuously valid for 4 packets. Only local packets are sent and `fwd_tready_o` stays 0. Local `tvalid` then drops, and FWD is granted at the next IDLE.
- Backpressure: `axi_tx_tready_i` toggles 1,0,0,1 mid-packet. Output data is held stable while stalled; no beat is lost or duplicated; the source sees `tready` = 0 while stalled.
- Watchdog: TIMEOUT = 8, `axi_tx_tready_i` held 0 for 10 cycles. `stall_err_o` = 1 after the 8th stalled cycle and remains set after `axi_tx_tready_i` returns. `clr_i` clears it. `clr_i` coincident with a `tlast` handshake gives counter = 1.
- Reset mid-packet and wrap-around:
  - Assert `c_rst_i` after beat 2 of a 4-beat packet: outputs are 0 immediately; after release the first request is granted to LOC.
  - With CNT_W = 4, after 17 local packets `loc_cnt_o` = 1.
